// File: rtl/axis_pkt_checker_pkg.sv
// Shared constants for the NanoNIC receive-side packet checker: field
// positions, error-flag bit indices and the throttle LFSR definition.
package axis_chk_defs;

  localparam int LEN_LSB = 0;
  localparam int LEN_W   = 16;
  localparam int MAC_W   = 48;

  localparam int ERR_LEN      = 0;
  localparam int ERR_KEEP     = 1;
  localparam int ERR_OVERSIZE = 2;
  localparam int ERR_USER_CHG = 3;
  localparam int ERR_W        = 4;

  typedef logic [ERR_W-1:0] err_vec_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/axis_pkt_checker_keep_analyzer.sv
// Combinational tkeep classifier: byte count, full-beat test and
// "contiguous from byte 0, nonzero" test for the closing beat.
module keep_analyzer #(
  parameter int KEEP_W = 64,
  parameter int PC_W   = $clog2(KEEP_W + 1)
) (
  input  logic [KEEP_W-1:0] i_tkeep,
  output logic [PC_W-1:0]   o_popcount,
  output logic              o_all_ones,
  output logic              o_contiguous_nonzero
);

  logic [KEEP_W-1:0] w_keep_inc;

  assign w_keep_inc = i_tkeep + KEEP_W'(1);
  assign o_all_ones = &i_tkeep;
  // 2^k-1 masks are exactly the values with no set bit shared with value+1.
  assign o_contiguous_nonzero = (|i_tkeep) && ((i_tkeep & w_keep_inc) == '0);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    o_popcount = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      o_popcount = o_popcount + {{(PC_W-1){1'b0}}, i_tkeep[i]};
    end
  end

endmodule

// File: rtl/axis_pkt_checker.sv
// AXI4-Stream sink that checks packet framing, captures MACs and keeps
// saturating statistics. Define AXIS_CHK_THROTTLE_EN for LFSR-driven tready.
module axis_pkt_checker
  import axis_chk_defs::*;
#(
  parameter int          DATA_W        = 512,
  parameter int          USER_W        = 48,
  parameter int          CNT_W         = 32,
  parameter int          MAX_PKT_BYTES = 9600,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic [USER_W-1:0]   s_axis_tuser,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                clr_stats,
  output logic                pkt_done,
  output logic                pkt_ok,
  output logic [LEN_W-1:0]    pkt_len,
  output logic [MAC_W-1:0]    pkt_dst_mac,
  output logic [MAC_W-1:0]    pkt_src_mac,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    byte_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [ERR_W-1:0]    err_flags
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PC_W   = $clog2(KEEP_W + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_BYTES);

  localparam logic ST_FIRST = 1'b0;
  localparam logic ST_BODY  = 1'b1;

  logic                r_state;
  logic                r_tready;
  logic [LEN_W-1:0]    r_acc;
  logic [LEN_W-1:0]    r_exp_len;
  logic [USER_W-1:0]   r_ref_user;
  err_vec_t            r_flags;
  logic [MAC_W-1:0]    r_dst_sh;
  logic [MAC_W-1:0]    r_src_sh;
  logic                r_done;
  logic                r_ok;
  logic [LEN_W-1:0]    r_len;
  logic [MAC_W-1:0]    r_dst;
  logic [MAC_W-1:0]    r_src;
  logic [CNT_W-1:0]    r_pkt_cnt;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [CNT_W-1:0]    r_err_cnt;
  err_vec_t            r_err_flags;

  logic [PC_W-1:0]     w_popcount;
  logic                w_all_ones;
  logic                w_contig;
  logic                w_accept;
  logic                w_first;
  logic                w_finish;
  logic [LEN_W-1:0]    w_acc_base;
  logic [LEN_W:0]      w_acc_sum;
  logic [LEN_W-1:0]    w_acc_next;
  logic [LEN_W-1:0]    w_exp_len;
  err_vec_t            w_beat_flags;
  err_vec_t            w_flags_next;
  err_vec_t            w_fin_flags;
  logic [MAC_W-1:0]    w_beat_dst;
  logic [MAC_W-1:0]    w_beat_src;
  logic [MAC_W-1:0]    w_dst_next;
  logic [MAC_W-1:0]    w_src_next;
  logic [CNT_W:0]      w_byte_sum;
  logic                w_unused;

  keep_analyzer #(
    .KEEP_W (KEEP_W),
    .PC_W   (PC_W)
  ) u_keep_analyzer (
    .i_tkeep              (s_axis_tkeep),
    .o_popcount           (w_popcount),
    .o_all_ones           (w_all_ones),
    .o_contiguous_nonzero (w_contig)
  );

  assign w_accept   = s_axis_tvalid && r_tready;
  assign w_first    = (r_state == ST_FIRST);
  assign w_finish   = w_accept && s_axis_tlast;
  assign w_acc_base = w_first ? '0 : r_acc;
  assign w_acc_sum  = {1'b0, w_acc_base} + (LEN_W+1)'(w_popcount);
  assign w_acc_next = w_acc_sum[LEN_W] ? '1 : w_acc_sum[LEN_W-1:0];
  assign w_exp_len  = w_first ? s_axis_tuser[LEN_LSB +: LEN_W] : r_exp_len;

  // A single-beat packet must see its own MACs, not the previous shadow.
  assign w_dst_next = w_first ? w_beat_dst : r_dst_sh;
  assign w_src_next = w_first ? w_beat_src : r_src_sh;

  always_comb begin
    w_beat_dst = '0;
    w_beat_src = '0;
    for (int i = 0; i < 6; i++) begin
      w_beat_dst[MAC_W-1-8*i -: 8] = s_axis_tdata[8*i +: 8];
      w_beat_src[MAC_W-1-8*i -: 8] = s_axis_tdata[8*(i+6) +: 8];
    end
  end

  always_comb begin
    w_beat_flags               = '0;
    w_beat_flags[ERR_KEEP]     = s_axis_tlast ? !w_contig : !w_all_ones;
    w_beat_flags[ERR_OVERSIZE] = (w_acc_next > MAX_LEN);
    w_beat_flags[ERR_USER_CHG] = !w_first && (s_axis_tuser != r_ref_user);
    w_flags_next               = (w_first ? '0 : r_flags) | w_beat_flags;
    w_fin_flags                = w_flags_next;
    w_fin_flags[ERR_LEN]       = (w_acc_next != w_exp_len);
  end

  // NOTE: sequential state is written with <= so every register in the block
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state    <= ST_FIRST;
      r_acc      <= '0;
      r_flags    <= '0;
      r_exp_len  <= '0;
      r_ref_user <= '0;
      r_dst_sh   <= '0;
      r_src_sh   <= '0;
      r_done     <= 1'b0;
      r_ok       <= 1'b0;
      r_len      <= '0;
      r_dst      <= '0;
      r_src      <= '0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        if (w_first) begin
          r_exp_len  <= s_axis_tuser[LEN_LSB +: LEN_W];
          r_ref_user <= s_axis_tuser;
          r_dst_sh   <= w_beat_dst;
          r_src_sh   <= w_beat_src;
        end
        if (s_axis_tlast) begin
          r_state <= ST_FIRST;
          r_acc   <= '0;
          r_flags <= '0;
        end else begin
          r_state <= ST_BODY;
          r_acc   <= w_acc_next;
          r_flags <= w_flags_next;
        end
      end
      if (w_finish) begin
        r_ok  <= ~|w_fin_flags;
        r_len <= w_acc_next;
        r_dst <= w_dst_next;
        r_src <= w_src_next;
      end
    end
  end

  assign w_byte_sum = {1'b0, r_byte_cnt} + (CNT_W+1)'(w_acc_next);

  // A clear coinciding with a finish drops that packet from the statistics.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || clr_stats) begin
      r_pkt_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_err_cnt   <= '0;
      r_err_flags <= '0;
    end else if (w_finish) begin
      if (r_pkt_cnt != '1) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
      r_byte_cnt <= w_byte_sum[CNT_W] ? '1 : w_byte_sum[CNT_W-1:0];
      if ((|w_fin_flags) && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      r_err_flags <= r_err_flags | w_fin_flags;
    end
  end

`ifdef AXIS_CHK_THROTTLE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_lfsr   <= LFSR_SEED;
      r_tready <= 1'b0;
    end else begin
      r_lfsr   <= lfsr_next(r_lfsr);
      r_tready <= (r_lfsr[1:0] != 2'b00);
    end
  end

  assign w_unused = ^s_axis_tdata[DATA_W-1:96];
`else
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_tready <= 1'b0;
    end else begin
      r_tready <= 1'b1;
    end
  end

  assign w_unused = ^{s_axis_tdata[DATA_W-1:96], LFSR_SEED};
`endif

  assign s_axis_tready = r_tready;
  assign pkt_done      = r_done;
  assign pkt_ok        = r_ok;
  assign pkt_len       = r_len;
  assign pkt_dst_mac   = r_dst;
  assign pkt_src_mac   = r_src;
  assign pkt_cnt       = r_pkt_cnt;
  assign byte_cnt      = r_byte_cnt;
  assign err_cnt       = r_err_cnt;
  assign err_flags     = r_err_flags;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed bench for axis_pkt_checker; the throttle section is compiled
// only when AXIS_CHK_THROTTLE_EN is defined.
module tb_axis_pkt_checker;

  localparam logic [63:0] ALL   = {64{1'b1}};
  localparam logic [63:0] K34   = 64'h3_FFFF_FFFF;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic         ap_clk;
  logic         ap_rst_n;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic [47:0]  s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         clr_stats;
  logic         pkt_done;
  logic         pkt_ok;
  logic [15:0]  pkt_len;
  logic [47:0]  pkt_dst_mac;
  logic [47:0]  pkt_src_mac;
  logic [31:0]  pkt_cnt;
  logic [31:0]  byte_cnt;
  logic [31:0]  err_cnt;
  logic [3:0]   err_flags;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;
  logic [511:0] d0;

  axis_pkt_checker dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .clr_stats     (clr_stats),
    .pkt_done      (pkt_done),
    .pkt_ok        (pkt_ok),
    .pkt_len       (pkt_len),
    .pkt_dst_mac   (pkt_dst_mac),
    .pkt_src_mac   (pkt_src_mac),
    .pkt_cnt       (pkt_cnt),
    .byte_cnt      (byte_cnt),
    .err_cnt       (err_cnt),
    .err_flags     (err_flags)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(negedge ap_clk) if (pkt_done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input logic [7:0] base);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] keep, input logic last,
                           input logic [47:0] user, input logic [511:0] data);
    logic acc;
    int   n;
    s_axis_tdata  = data;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    n = 0;
    do begin
      acc = s_axis_tready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      s_axis_tkeep = {$urandom, $urandom};
      s_axis_tuser = {16'($urandom), $urandom};
      s_axis_tlast = 1'($urandom);
      tick();
    end
  endtask

  task automatic pulse_clr();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  task automatic send_pkt98(input logic [47:0] user);
    send_beat(ALL, 1'b0, user, d0);
    send_beat(K34, 1'b1, user, mk_data(8'h80));
  endtask

  task automatic send_pkt70();
    send_beat(ALL, 1'b0, 48'h46, mk_data(8'h40));
    send_beat(64'h3F, 1'b1, 48'h46, mk_data(8'hC0));
  endtask

`ifdef AXIS_CHK_THROTTLE_EN
  logic [15:0] m_lfsr;
  logic        m_rdy;
  logic        rdy_chk_en = 1'b0;
  logic        rdy_prev   = 1'b0;
  int          rdy_toggles = 0;

  always @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      m_lfsr <= SEED;
      m_rdy  <= 1'b0;
    end else begin
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_rdy  <= (m_lfsr[1:0] != 2'b00);
    end
  end

  always @(negedge ap_clk) begin
    if (rdy_chk_en) begin
      check("tready_vs_lfsr", {63'd0, s_axis_tready}, {63'd0, m_rdy});
      if (s_axis_tready !== rdy_prev) rdy_toggles++;
      rdy_prev = s_axis_tready;
    end
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dref;
    d0 = mk_data(8'h10);
    ap_rst_n = 1'b0;
    clr_stats = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = '0;

    // Reset state
    repeat (3) tick();
    check("rst_tready", {63'd0, s_axis_tready}, 64'd0);
    check("rst_done", {63'd0, pkt_done}, 64'd0);
    check("rst_ok", {63'd0, pkt_ok}, 64'd0);
    check("rst_len", {48'd0, pkt_len}, 64'd0);
    check("rst_dst", {16'd0, pkt_dst_mac}, 64'd0);
    check("rst_src", {16'd0, pkt_src_mac}, 64'd0);
    check("rst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
    check("rst_byte_cnt", {32'd0, byte_cnt}, 64'd0);
    check("rst_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("rst_err_flags", {60'd0, err_flags}, 64'd0);
    ap_rst_n = 1'b1;
`ifdef AXIS_CHK_THROTTLE_EN
    rdy_chk_en = 1'b1;
    tick();
`else
    tick();
    check("tready_after_rst", {63'd0, s_axis_tready}, 64'd1);
`endif

    // 1: 98-byte two-beat packet
    send_pkt98(48'h62);
    check("t1_done", {63'd0, pkt_done}, 64'd1);
    check("t1_ok", {63'd0, pkt_ok}, 64'd1);
    check("t1_len", {48'd0, pkt_len}, 64'd98);
    check("t1_pkt_cnt", {32'd0, pkt_cnt}, 64'd1);
    check("t1_byte_cnt", {32'd0, byte_cnt}, 64'd98);
    check("t1_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("t1_dst", {16'd0, pkt_dst_mac}, 64'h1011_1213_1415);
    check("t1_src", {16'd0, pkt_src_mac}, 64'h1617_1819_1A1B);
    idle(1);
    check("t1_done_pulse", {63'd0, pkt_done}, 64'd0);

    // 2: back-to-back packets
    pulse_clr();
    dref = 32'(done_seen);
    send_pkt98(48'h62);
    check("t2_done_a", {63'd0, pkt_done}, 64'd1);
    send_pkt70();
    check("t2_done_b", {63'd0, pkt_done}, 64'd1);
    check("t2_len_b", {48'd0, pkt_len}, 64'd70);
    check("t2_dst_b", {16'd0, pkt_dst_mac}, 64'h4041_4243_4445);
    idle(2);
    check("t2_done_pulses", 64'(done_seen) - 64'(dref), 64'd2);
    check("t2_pkt_cnt", {32'd0, pkt_cnt}, 64'd2);
    check("t2_byte_cnt", {32'd0, byte_cnt}, 64'd168);
    check("t2_err_cnt", {32'd0, err_cnt}, 64'd0);

    // 3: length mismatch
    send_pkt98(48'h60);
    check("t3_ok", {63'd0, pkt_ok}, 64'd0);
    check("t3_len", {48'd0, pkt_len}, 64'd98);
    check("t3_err_flags", {60'd0, err_flags}, 64'b0001);
    check("t3_err_cnt", {32'd0, err_cnt}, 64'd1);
    idle(1);

    // 4: keep errors, then tuser change
    pulse_clr();
    send_beat(64'h5, 1'b1, 48'h2, d0);
    check("t4a_done", {63'd0, pkt_done}, 64'd1);
    check("t4a_ok", {63'd0, pkt_ok}, 64'd0);
    check("t4a_len", {48'd0, pkt_len}, 64'd2);
    check("t4a_flags", {60'd0, err_flags}, 64'b0010);
    check("t4a_err_cnt", {32'd0, err_cnt}, 64'd1);
    send_beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 48'h40, d0);
    send_beat(64'h1, 1'b1, 48'h40, d0);
    check("t4b_ok", {63'd0, pkt_ok}, 64'd0);
    check("t4b_len", {48'd0, pkt_len}, 64'd64);
    check("t4b_flags", {60'd0, err_flags}, 64'b0010);
    check("t4b_err_cnt", {32'd0, err_cnt}, 64'd2);
    send_beat(ALL, 1'b0, 48'h62, d0);
    send_beat(K34, 1'b1, 48'h1_0000_0062, d0);
    check("t4c_ok", {63'd0, pkt_ok}, 64'd0);
    check("t4c_len", {48'd0, pkt_len}, 64'd98);
    check("t4c_flags", {60'd0, err_flags}, 64'b1010);
    check("t4c_err_cnt", {32'd0, err_cnt}, 64'd3);
    idle(1);

    // Oversize boundary: 9600 bytes is legal, 9664 is not
    pulse_clr();
    for (int b = 0; b < 149; b++) send_beat(ALL, 1'b0, 48'd9600, d0);
    send_beat(ALL, 1'b1, 48'd9600, d0);
    check("max_ok", {63'd0, pkt_ok}, 64'd1);
    check("max_len", {48'd0, pkt_len}, 64'd9600);
    for (int b = 0; b < 150; b++) send_beat(ALL, 1'b0, 48'd9664, d0);
    send_beat(ALL, 1'b1, 48'd9664, d0);
    check("over_ok", {63'd0, pkt_ok}, 64'd0);
    check("over_len", {48'd0, pkt_len}, 64'd9664);
    check("over_flags", {60'd0, err_flags}, 64'b0100);
    check("over_err_cnt", {32'd0, err_cnt}, 64'd1);
    idle(1);

    // 5: reset mid-packet, then clear coincident with a finish
    dref = 32'(done_seen);
    send_beat(ALL, 1'b0, 48'h62, d0);
    s_axis_tvalid = 1'b0;
    ap_rst_n = 1'b0;
    tick();
    tick();
    check("t5_rst_tready", {63'd0, s_axis_tready}, 64'd0);
    check("t5_rst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
    ap_rst_n = 1'b1;
    idle(2);
    check("t5_no_partial_done", 64'(done_seen) - 64'(dref), 64'd0);
    send_pkt70();
    check("t5_done", {63'd0, pkt_done}, 64'd1);
    check("t5_ok", {63'd0, pkt_ok}, 64'd1);
    check("t5_pkt_cnt", {32'd0, pkt_cnt}, 64'd1);
    check("t5_len", {48'd0, pkt_len}, 64'd70);
    check("t5_byte_cnt", {32'd0, byte_cnt}, 64'd70);
    idle(1);
    send_beat(ALL, 1'b0, 48'h60, d0);
    clr_stats = 1'b1;
    send_beat(K34, 1'b1, 48'h60, d0);
    clr_stats = 1'b0;
    check("t5_clr_done", {63'd0, pkt_done}, 64'd1);
    check("t5_clr_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
    check("t5_clr_byte_cnt", {32'd0, byte_cnt}, 64'd0);
    check("t5_clr_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("t5_clr_flags", {60'd0, err_flags}, 64'd0);
    idle(1);

`ifdef AXIS_CHK_THROTTLE_EN
    // 6: random packets under LFSR throttle, tvalid held high
    begin
      logic [31:0] exp_bytes;
      exp_bytes = 0;
      pulse_clr();
      for (int p = 0; p < 100; p++) begin
        int nb;
        int k;
        logic [63:0] lk;
        logic [15:0] len;
        nb = int'($urandom_range(1, 4));
        k  = int'($urandom_range(1, 64));
        lk = ALL >> (64 - k);
        len = 16'(64 * (nb - 1) + k);
        exp_bytes = exp_bytes + 32'(len);
        for (int b = 0; b < nb; b++) begin
          if (b == nb - 1) send_beat(lk, 1'b1, {32'd0, len}, mk_data(8'(p)));
          else             send_beat(ALL, 1'b0, {32'd0, len}, mk_data(8'(p)));
        end
      end
      idle(2);
      check("t6_pkt_cnt", {32'd0, pkt_cnt}, 64'd100);
      check("t6_err_cnt", {32'd0, err_cnt}, 64'd0);
      check("t6_byte_cnt", {32'd0, byte_cnt}, {32'd0, exp_bytes});
      check("t6_tready_toggles", {63'd0, (rdy_toggles > 10)}, 64'd1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
